spi_frame_decoder: RTL and testbench

//  Parametrised SPI slave (mode 0, MSB first) that receives operand/opcode frames from the

---
 rtl/spi_frame_pkg.sv | 35 +++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_frame_decoder.sv | 170 +++++++++++++++++
 tb/tb_spi_frame_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame decoder.
//   state_t   : decoder FSM states
//   DEF_*     : default widths for the frame layout and synchroniser depth
//   field_lsb : LSB position of a field inside the received frame
package spi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_OP_W        = 4;
    localparam int DEF_OPC_W       = 2;
    localparam int DEF_FRAME_W     = 16;
    localparam int DEF_RESP_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;

    localparam int FIELD_OP1 = 0;
    localparam int FIELD_OP2 = 1;
    localparam int FIELD_OPC = 2;

    // Fields are packed MSB first: operand1, operand2, opcode, then ignored padding.
    function automatic int field_lsb(input int frame_w, input int op_w,
                                     input int opc_w, input int field_idx);
        int lsb;
        case (field_idx)
            FIELD_OP1: lsb = frame_w - op_w;
            FIELD_OP2: lsb = frame_w - 2 * op_w;
            default:   lsb = frame_w - 2 * op_w - opc_w;
        endcase
        return lsb;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with edge detection for one asynchronous input.
//   clk, reset_n : system clock, asynchronous active-low reset
//   din          : asynchronous input pin
//   dout         : synchronised level
//   rise, fall   : single-cycle pulses on edges of the synchronised level
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_reg <= {STAGES{RESET_VAL}};
            prev_reg  <= RESET_VAL;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
            prev_reg  <= chain_reg[STAGES-1];
        end
    end

    assign dout = chain_reg[STAGES-1];
    assign rise = dout & ~prev_reg;
    assign fall = ~dout & prev_reg;

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI slave (mode 0, MSB first) that deserialises fixed-length frames into
// operand1/operand2/opcode fields and returns a response word on MISO.
//   clk, reset_n          : system clock (>= 8x sclk), asynchronous active-low reset
//   spi_sclk/mosi/ss_n    : asynchronous SPI pins from the host
//   spi_miso              : response bit, 0 outside a frame
//   resp_data, resp_load  : response word and its capture strobe
//   operand1/2, opcode    : decoded fields, held until the next valid frame
//   frame_valid           : 1-cycle pulse when fields update
//   frame_err             : 1-cycle pulse when a frame had the wrong bit count
//   busy                  : high while a frame is being shifted
module spi_frame_decoder
    import spi_frame_pkg::*;
#(
    parameter int OP_W        = DEF_OP_W,
    parameter int OPC_W       = DEF_OPC_W,
    parameter int FRAME_W     = DEF_FRAME_W,
    parameter int RESP_W      = DEF_RESP_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    input  logic [RESP_W-1:0] resp_data,
    input  logic              resp_load,
    output logic [OP_W-1:0]   operand1,
    output logic [OP_W-1:0]   operand2,
    output logic [OPC_W-1:0]  opcode,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              busy
);

    generate
        if (FRAME_W < 2 * OP_W + OPC_W) begin : g_bad_frame_w
            $error("FRAME_W too small for operand and opcode fields");
        end
        if (RESP_W > FRAME_W) begin : g_bad_resp_w
            $error("RESP_W must not exceed FRAME_W");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
    endgenerate

    localparam int OP1_LSB = field_lsb(FRAME_W, OP_W, OPC_W, FIELD_OP1);
    localparam int OP2_LSB = field_lsb(FRAME_W, OP_W, OPC_W, FIELD_OP2);
    localparam int OPC_LSB = field_lsb(FRAME_W, OP_W, OPC_W, FIELD_OPC);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int SET_W   = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SYNC_STAGES);

    // Synchronised pins
    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .din(spi_sclk),
        .dout(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .din(spi_ss_n),
        .dout(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .din(spi_mosi),
        .dout(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_t             state_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [FRAME_W-1:0] rx_shift_reg;
    logic [FRAME_W-1:0] tx_shift_reg;
    logic [RESP_W-1:0]  resp_hold_reg;
    logic [SET_W-1:0]   settle_reg;
    logic               armed_reg;
    logic [RESP_W-1:0]  resp_word;

    // A load coinciding with the start of a frame must reach that frame.
    assign resp_word = resp_load ? resp_data : resp_hold_reg;

    // After reset the synchroniser holds its reset value rather than a real
    // sample; wait until it has been refilled and then require ss_n high
    // before accepting a frame start. This drops a frame already in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            resp_hold_reg <= '0;
            settle_reg    <= '0;
            armed_reg     <= 1'b0;
            operand1      <= '0;
            operand2      <= '0;
            opcode        <= '0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (resp_load) begin
                resp_hold_reg <= resp_data;
            end

            if (!armed_reg) begin
                if (settle_reg != SET_MAX) begin
                    settle_reg <= settle_reg + 1'b1;
                end else if (ss_level) begin
                    armed_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (armed_reg && ss_fall) begin
                        state_reg    <= SHIFT;
                        bit_cnt_reg  <= '0;
                        tx_shift_reg <= FRAME_W'(resp_word) << (FRAME_W - RESP_W);
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        if (bit_cnt_reg == CNT_FULL) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rx_shift_reg <= {rx_shift_reg[FRAME_W-2:0], mosi_level};
                            if (bit_cnt_reg != CNT_SAT) begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift_reg <= tx_shift_reg << 1;
                        end
                    end
                end
                DONE: begin
                    operand1    <= rx_shift_reg[OP1_LSB +: OP_W];
                    operand2    <= rx_shift_reg[OP2_LSB +: OP_W];
                    opcode      <= rx_shift_reg[OPC_LSB +: OPC_W];
                    frame_valid <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = (state_reg == SHIFT);
    assign spi_miso = (state_reg == SHIFT) & tx_shift_reg[FRAME_W-1];

    // Padding bits below the opcode and the unused edge/level taps.
    logic unused_sigs;
    assign unused_sigs = ^{rx_shift_reg, sclk_level, mosi_rise, mosi_fall};

endmodule

// File: tb/tb_spi_frame_decoder.sv
module tb_spi_frame_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       spi_miso;
    logic [7:0] resp_data = 8'h00;
    logic       resp_load = 1'b0;
    logic [3:0] operand1;
    logic [3:0] operand2;
    logic [1:0] opcode;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;

    spi_frame_decoder dut (
        .clk(clk), .reset_n(reset_n),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .spi_miso(spi_miso), .resp_data(resp_data), .resp_load(resp_load),
        .operand1(operand1), .operand2(operand2), .opcode(opcode),
        .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_lat = 0;
    logic [31:0] miso_bits;

    always @(negedge clk) begin
        if (frame_valid) valid_cnt++;
        if (frame_err) err_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_half();
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [7:0] v);
        resp_data = v;
        resp_load = 1'b1;
        @(negedge clk);
        resp_load = 1'b0;
    endtask

    // Host side of one bit group: mode 0, data changes on the falling edge,
    // MISO sampled on the rising edge.
    task automatic spi_bits(input logic [31:0] data, input int nbits,
                            input int load_at, input logic [7:0] load_val);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = data[nbits-1-i];
            wait_half();
            spi_sclk = 1'b1;
            miso_bits = {miso_bits[30:0], spi_miso};
            if (i == load_at) pulse_load(load_val);
            wait_half();
            spi_sclk = 1'b0;
        end
    endtask

    // Deassert select, then watch 20 cycles (2 sclk periods) for the result.
    task automatic spi_end();
        wait_half();
        spi_ss_n = 1'b1;
        last_lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (frame_valid && last_lat == 0) last_lat = c;
        end
    endtask

    task automatic spi_xfer(input logic [31:0] data, input int nbits,
                            input int load_at, input logic [7:0] load_val);
        miso_bits = '0;
        spi_ss_n = 1'b0;
        wait_half();
        spi_bits(data, nbits, load_at, load_val);
        spi_end();
    endtask

    typedef struct {
        logic [31:0] data;
        int          nbits;
        logic        load;
        logic [7:0]  resp;
        logic        exp_valid;
        logic [3:0]  e_op1;
        logic [3:0]  e_op2;
        logic [1:0]  e_opc;
        logic [31:0] e_miso;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0, e0;

        vecs[0] = '{32'hA7C0,  16, 1'b1, 8'h5A, 1'b1, 4'hA, 4'h7, 2'd3, 32'h5A00};
        vecs[1] = '{32'h3480,  16, 1'b0, 8'h00, 1'b1, 4'h3, 4'h4, 2'd2, 32'h5A00};
        vecs[2] = '{32'h03FF,  10, 1'b0, 8'h00, 1'b0, 4'h3, 4'h4, 2'd2, 32'h0168};
        vecs[3] = '{32'h1FFFF, 17, 1'b0, 8'h00, 1'b0, 4'h3, 4'h4, 2'd2, 32'hB400};
        vecs[4] = '{32'h1240,  16, 1'b0, 8'h00, 1'b1, 4'h1, 4'h2, 2'd1, 32'h5A00};
        vecs[5] = '{32'hFFC0,  16, 1'b1, 8'h81, 1'b1, 4'hF, 4'hF, 2'd3, 32'h8100};
        vecs[6] = '{32'h5A3F,  16, 1'b0, 8'h00, 1'b1, 4'h5, 4'hA, 2'd0, 32'h8100};
        vecs[7] = '{32'h0000,  16, 1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 2'd0, 32'h8100};

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset op1", 32'(operand1), 32'h0);
        chk("reset op2", 32'(operand2), 32'h0);
        chk("reset opc", 32'(opcode), 32'h0);
        chk("reset valid", 32'(frame_valid), 32'h0);
        chk("reset err", 32'(frame_err), 32'h0);
        chk("reset miso", 32'(spi_miso), 32'h0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].load) pulse_load(vecs[i].resp);
            v0 = valid_cnt;
            e0 = err_cnt;
            spi_xfer(vecs[i].data, vecs[i].nbits, -1, 8'h00);
            $display("frame %0d: data=0x%0h bits=%0d -> op1=%0h op2=%0h opc=%0d miso=0x%0h lat=%0d",
                     i, vecs[i].data, vecs[i].nbits, operand1, operand2, opcode, miso_bits, last_lat);
            chk($sformatf("row%0d valid_pulses", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
            chk($sformatf("row%0d err_pulses", i), 32'(err_cnt - e0), 32'(!vecs[i].exp_valid));
            chk($sformatf("row%0d op1", i), 32'(operand1), 32'(vecs[i].e_op1));
            chk($sformatf("row%0d op2", i), 32'(operand2), 32'(vecs[i].e_op2));
            chk($sformatf("row%0d opc", i), 32'(opcode), 32'(vecs[i].e_opc));
            chk($sformatf("row%0d miso", i), miso_bits, vecs[i].e_miso);
            chk($sformatf("row%0d busy_after", i), 32'(busy), 32'h0);
            if (vecs[i].exp_valid) chk($sformatf("row%0d latency", i), 32'(last_lat), 32'd4);
        end

        // Response loaded mid-frame applies only to the following frame.
        pulse_load(8'h5A);
        spi_xfer(32'h1240, 16, 7, 8'hC3);
        $display("midload frame A: miso=0x%0h op1=%0h op2=%0h opc=%0d", miso_bits, operand1, operand2, opcode);
        chk("midload cur miso", miso_bits, 32'h5A00);
        chk("midload cur op1", 32'(operand1), 32'h1);
        chk("midload cur opc", 32'(opcode), 32'h1);
        spi_xfer(32'hA7C0, 16, -1, 8'h00);
        $display("midload frame B: miso=0x%0h", miso_bits);
        chk("midload next miso", miso_bits, 32'hC300);

        // Reset in the middle of a frame, release with select still low.
        miso_bits = '0;
        spi_ss_n = 1'b0;
        wait_half();
        spi_bits(32'hA7, 8, -1, 8'h00);
        chk("midreset busy_before", 32'(busy), 32'h1);
        v0 = valid_cnt;
        e0 = err_cnt;
        reset_n = 1'b0;
        #1;
        chk("midreset op1", 32'(operand1), 32'h0);
        chk("midreset op2", 32'(operand2), 32'h0);
        chk("midreset opc", 32'(opcode), 32'h0);
        chk("midreset busy", 32'(busy), 32'h0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        spi_bits(32'hC0, 8, -1, 8'h00);
        spi_end();
        $display("midreset tail: valid=%0d err=%0d op1=%0h", valid_cnt - v0, err_cnt - e0, operand1);
        chk("midreset no_valid", 32'(valid_cnt - v0), 32'h0);
        chk("midreset no_err", 32'(err_cnt - e0), 32'h0);
        chk("midreset op1_hold", 32'(operand1), 32'h0);
        v0 = valid_cnt;
        spi_xfer(32'hA7C0, 16, -1, 8'h00);
        $display("postreset frame: op1=%0h op2=%0h opc=%0d miso=0x%0h", operand1, operand2, opcode, miso_bits);
        chk("postreset valid", 32'(valid_cnt - v0), 32'h1);
        chk("postreset op1", 32'(operand1), 32'hA);
        chk("postreset op2", 32'(operand2), 32'h7);
        chk("postreset opc", 32'(opcode), 32'h3);
        chk("postreset miso", miso_bits, 32'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
